// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for data_mem_mmio: peripheral address map, MemSize encodings
// and the active-low hex glyph table used by the display scanner.
package data_mem_pkg;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LEDS   = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIRECT = 32'h4000_0010;
  localparam logic [31:0] ADDR_DISP   = 32'h4000_0014;
  localparam logic [31:0] ADDR_CTRL   = 32'h4000_0018;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off; entry 0 is the rightmost element
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// MEM-stage load/store bus between the pipeline (master) and data_mem_mmio (slave).
interface data_mem_mmio_if;
  logic [31:0] addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] ReadData;
  logic        misaligned;

  modport master (
    output addr, WriteData, MemRead, MemWrite, MemSize, MemSigned,
    input  ReadData, misaligned
  );

  modport slave (
    input  addr, WriteData, MemRead, MemWrite, MemSize, MemSigned,
    output ReadData, misaligned
  );
endinterface

// File: rtl/data_mem_mmio_seg7_scan.sv
// Free-running 7-segment scanner: holds each digit SCAN_DIV cycles and emits the
// active-low anode one-hot plus the glyph of the selected DISP nibble.
module seg7_scan
  import data_mem_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   disp_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [7:0]            bcd_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_sh;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    disp_sh = disp_i >> (4 * idx_q);
    an_o    = ~(DIGITS'(1) << idx_q);
    bcd_o   = seg_glyph(disp_sh[3:0]);
  end

endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data memory: word RAM with byte/halfword lanes plus LED, display and
// optional timer registers. Timer present only when DATA_MEM_TIMER_EN is defined.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 512,
  parameter int LED_WIDTH = 8,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_mmio_if.slave       bus,
  output logic [LED_WIDTH-1:0] leds,
  output logic [DIGITS-1:0]    AN,
  output logic [7:0]           BCD,
  output logic                 irq
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_DEPTH);

  logic [31:0] mem [MEM_DEPTH];

  logic                 is_word, is_half, in_ram, wr_ok, ram_we, per_wr;
  logic [AW-1:0]        ram_idx;
  logic [31:0]          ram_word, ram_sh, wd_sh, ram_rdata, rdata;
  logic [3:0]           be;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [DIGITS+7:0]    direct_q, direct_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic                 ctrl_q, ctrl_d;
  logic [DIGITS-1:0]    scan_an;
  logic [7:0]           scan_bcd;

  always_comb begin
    is_word        = bus.MemSize[1];
    is_half        = (bus.MemSize == SIZE_HALF);
    bus.misaligned = (bus.MemRead | bus.MemWrite) &
                     ((is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00)));
    in_ram         = (bus.addr < RAM_BYTES);
    wr_ok          = bus.MemWrite & ~bus.misaligned & ~reset;
    ram_we         = wr_ok & in_ram;
    per_wr         = wr_ok & ~in_ram & is_word;
    ram_idx        = bus.addr[AW+1:2];
    ram_word       = mem[ram_idx];
    ram_sh         = ram_word >> {bus.addr[1:0], 3'b000};
    wd_sh          = bus.WriteData << {bus.addr[1:0], 3'b000};
    if (is_word)      be = 4'b1111;
    else if (is_half) be = 4'b0011 << bus.addr[1:0];
    else              be = 4'b0001 << bus.addr[1:0];
    if (is_word)      ram_rdata = ram_word;
    else if (is_half) ram_rdata = {{16{bus.MemSigned & ram_sh[15]}}, ram_sh[15:0]};
    else              ram_rdata = {{24{bus.MemSigned & ram_sh[7]}}, ram_sh[7:0]};
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[ram_idx][8*b +: 8] <= wd_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    leds_d   = leds_q;
    direct_d = direct_q;
    disp_d   = disp_q;
    ctrl_d   = ctrl_q;
    if (per_wr) begin
      case (bus.addr)
        ADDR_LEDS:   leds_d   = bus.WriteData[LED_WIDTH-1:0];
        ADDR_DIRECT: direct_d = bus.WriteData[DIGITS+7:0];
        ADDR_DISP:   disp_d   = bus.WriteData[4*DIGITS-1:0];
        ADDR_CTRL:   ctrl_d   = bus.WriteData[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q   <= '0;
      direct_q <= '0;
      disp_q   <= '0;
      ctrl_q   <= 1'b0;
    end else begin
      leds_q   <= leds_d;
      direct_q <= direct_d;
      disp_q   <= disp_d;
      ctrl_q   <= ctrl_d;
    end
  end

`ifdef DATA_MEM_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  // CPU writes are applied last so they override increment and overflow
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (per_wr && bus.addr == ADDR_TH)   th_d   = bus.WriteData;
    if (per_wr && bus.addr == ADDR_TL)   tl_d   = bus.WriteData;
    if (per_wr && bus.addr == ADDR_TCON) tcon_d = bus.WriteData[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign irq = tcon_q[2];
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (bus.MemRead && !bus.misaligned) begin
      if (in_ram) begin
        rdata = ram_rdata;
      end else if (is_word) begin
        case (bus.addr)
`ifdef DATA_MEM_TIMER_EN
          ADDR_TH:     rdata = th_q;
          ADDR_TL:     rdata = tl_q;
          ADDR_TCON:   rdata = 32'(tcon_q);
`endif
          ADDR_LEDS:   rdata = 32'(leds_q);
          ADDR_DIRECT: rdata = 32'(direct_q);
          ADDR_DISP:   rdata = 32'(disp_q);
          ADDR_CTRL:   rdata = 32'(ctrl_q);
          default:     rdata = '0;
        endcase
      end
    end
    bus.ReadData = rdata;
  end

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .disp_i (disp_q),
    .an_o   (scan_an),
    .bcd_o  (scan_bcd)
  );

  always_comb begin
    leds = leds_q;
    AN   = ctrl_q ? scan_an  : direct_q[DIGITS+7:8];
    BCD  = ctrl_q ? scan_bcd : direct_q[7:0];
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM lanes, alignment, peripherals, reset, scanner, timer.
module tb_data_mem_mmio;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds;
  logic [3:0] AN;
  logic [7:0] BCD;
  logic       irq;
  int         n_cmp = 0;
  int         n_err = 0;

  data_mem_mmio_if bus();

  data_mem_mmio #(
    .MEM_DEPTH (512),
    .LED_WIDTH (8),
    .DIGITS    (4),
    .SCAN_DIV  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds),
    .AN    (AN),
    .BCD   (BCD),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    bus.addr = a; bus.WriteData = d; bus.MemSize = sz;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b1;
    @(posedge clk);
    #1 bus.MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          output logic [31:0] rd);
    @(negedge clk);
    bus.addr = a; bus.MemSize = sz; bus.MemSigned = sg;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b1;
    #1 rd = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (leds !== 8'h00) begin n_err++; $display("FAIL reset_leds: got %h want 00", leds); end
    n_cmp++; if (AN !== 4'h0) begin n_err++; $display("FAIL reset_an: got %b want 0000", AN); end
    n_cmp++; if (BCD !== 8'h00) begin n_err++; $display("FAIL reset_bcd: got %h want 00", BCD); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_err++; $display("FAIL idle_rdata: got %h want 0", bus.ReadData); end
  endtask

  task automatic test_ram_lanes;
    logic [31:0] rd;
    bus_write(32'h10, 32'h1234_5678, 2'b10);
    bus_write(32'h11, 32'h0000_00AB, 2'b00);
    bus_read(32'h10, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_err++; $display("FAIL byte_store_word: got %h want 1234ab78", rd); end
    bus_read(32'h11, 2'b00, 1'b1, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFAB) begin n_err++; $display("FAIL byte_signed: got %h want ffffffab", rd); end
    bus_read(32'h11, 2'b00, 1'b0, rd);
    n_cmp++; if (rd !== 32'h0000_00AB) begin n_err++; $display("FAIL byte_unsigned: got %h want 000000ab", rd); end
    bus_write(32'h14, 32'h0000_0000, 2'b11);
    bus_write(32'h16, 32'h0000_BEEF, 2'b01);
    bus_read(32'h14, 2'b11, 1'b0, rd);
    n_cmp++; if (rd !== 32'hBEEF_0000) begin n_err++; $display("FAIL half_store_word: got %h want beef0000", rd); end
    bus_read(32'h16, 2'b01, 1'b1, rd);
    n_cmp++; if (rd !== 32'hFFFF_BEEF) begin n_err++; $display("FAIL half_signed: got %h want ffffbeef", rd); end
    bus_write(32'h7FC, 32'hCAFE_F00D, 2'b10);
    bus_read(32'h7FC, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL top_word: got %h want cafef00d", rd); end
    bus_read(32'h800, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL past_ram: got %h want 0", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd;
    @(negedge clk);
    bus.addr = 32'h12; bus.WriteData = 32'hDEAD_BEEF; bus.MemSize = 2'b10; bus.MemWrite = 1'b1;
    #1;
    n_cmp++; if (bus.misaligned !== 1'b1) begin n_err++; $display("FAIL mis_word_wr: got %b want 1", bus.misaligned); end
    @(posedge clk);
    #1 bus.MemWrite = 1'b0;
    bus_read(32'h10, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_err++; $display("FAIL mis_wr_suppressed: got %h want 1234ab78", rd); end
    @(negedge clk);
    bus.addr = 32'h12; bus.MemSize = 2'b10; bus.MemRead = 1'b1;
    #1;
    n_cmp++; if (bus.misaligned !== 1'b1) begin n_err++; $display("FAIL mis_word_rd: got %b want 1", bus.misaligned); end
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_err++; $display("FAIL mis_rdata: got %h want 0", bus.ReadData); end
    bus.addr = 32'h11; bus.MemSize = 2'b01;
    #1;
    n_cmp++; if (bus.misaligned !== 1'b1) begin n_err++; $display("FAIL mis_half: got %b want 1", bus.misaligned); end
    bus.addr = 32'h13; bus.MemSize = 2'b00; bus.MemSigned = 1'b0;
    #1;
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_err++; $display("FAIL byte_aligned: got %b want 0", bus.misaligned); end
    n_cmp++; if (bus.ReadData !== 32'h12) begin n_err++; $display("FAIL byte3_read: got %h want 00000012", bus.ReadData); end
    bus.MemRead = 1'b0; bus.addr = 32'h12; bus.MemSize = 2'b10;
    #1;
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_err++; $display("FAIL mis_unqualified: got %b want 0", bus.misaligned); end
    @(negedge clk);
    bus.addr = 32'h10; bus.WriteData = 32'hFFFF_FFFF; bus.MemWrite = 1'b0;
    @(posedge clk);
    bus_read(32'h10, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_err++; $display("FAIL no_memwrite: got %h want 1234ab78", rd); end
  endtask

  task automatic test_periph;
    logic [31:0] rd;
    bus_write(32'h4000_000C, 32'h0000_00A5, 2'b10);
    n_cmp++; if (leds !== 8'hA5) begin n_err++; $display("FAIL leds_write: got %h want a5", leds); end
    bus_write(32'h4000_0010, 32'h0000_0E3F, 2'b10);
    n_cmp++; if (AN !== 4'hE) begin n_err++; $display("FAIL direct_an: got %h want e", AN); end
    n_cmp++; if (BCD !== 8'h3F) begin n_err++; $display("FAIL direct_bcd: got %h want 3f", BCD); end
    bus_read(32'h4000_000C, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hA5) begin n_err++; $display("FAIL leds_read: got %h want a5", rd); end
    bus_read(32'h4000_0010, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hE3F) begin n_err++; $display("FAIL direct_read: got %h want e3f", rd); end
    bus_write(32'h4000_000C, 32'h0000_005A, 2'b00);
    n_cmp++; if (leds !== 8'hA5) begin n_err++; $display("FAIL periph_byte_wr: got %h want a5", leds); end
    bus_read(32'h4000_000C, 2'b00, 1'b0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL periph_byte_rd: got %h want 0", rd); end
    bus_read(32'h4000_0020, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", rd); end
  endtask

  task automatic test_reset_retain;
    logic [31:0] rd;
    @(negedge clk);
    reset = 1'b1;
    bus.addr = 32'h4000_000C; bus.WriteData = 32'hFF; bus.MemSize = 2'b10; bus.MemWrite = 1'b1;
    @(negedge clk);
    bus.addr = 32'h10; bus.WriteData = 32'h0BAD_0BAD;
    @(negedge clk);
    reset = 1'b0; bus.MemWrite = 1'b0;
    n_cmp++; if (leds !== 8'h00) begin n_err++; $display("FAIL rst_leds: got %h want 00", leds); end
    n_cmp++; if (AN !== 4'h0) begin n_err++; $display("FAIL rst_an: got %h want 0", AN); end
    n_cmp++; if (BCD !== 8'h00) begin n_err++; $display("FAIL rst_bcd: got %h want 00", BCD); end
    bus_read(32'h10, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h1234_AB78) begin n_err++; $display("FAIL rst_ram_retained: got %h want 1234ab78", rd); end
  endtask

  task automatic test_scan;
    logic [7:0] exp_g [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [3:0] exp_an;
    int         idx;
    int         guard;
    bus_write(32'h4000_0014, 32'h0000_1234, 2'b10);
    bus_write(32'h4000_0018, 32'h0000_0001, 2'b10);
    @(negedge clk);
    guard = 0;
    while (AN === 4'b1101 && guard < 40) begin @(negedge clk); guard++; end
    while (AN !== 4'b1101 && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (AN !== 4'b1101) begin n_err++; $display("FAIL scan_sync_timeout: got %b want 1101", AN); end
    for (int k = 0; k < 16; k++) begin
      idx    = (1 + k / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      n_cmp++; if (AN !== exp_an) begin n_err++; $display("FAIL scan_an[%0d]: got %b want %b", k, AN, exp_an); end
      n_cmp++; if (BCD !== exp_g[idx]) begin n_err++; $display("FAIL scan_bcd[%0d]: got %h want %h", k, BCD, exp_g[idx]); end
      @(negedge clk);
    end
    bus_write(32'h4000_0018, 32'h0000_0000, 2'b10);
    n_cmp++; if (AN !== 4'h0) begin n_err++; $display("FAIL manual_an: got %b want 0000", AN); end
    n_cmp++; if (BCD !== 8'h00) begin n_err++; $display("FAIL manual_bcd: got %h want 00", BCD); end
  endtask

  task automatic test_timer;
    logic [31:0] rd;
`ifdef DATA_MEM_TIMER_EN
    bus_write(32'h4000_0000, 32'hFFFF_FFFE, 2'b10);
    bus_write(32'h4000_0004, 32'hFFFF_FFFE, 2'b10);
    bus_write(32'h4000_0008, 32'h0000_0003, 2'b10);
    bus_read(32'h4000_0004, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL tl_start: got %h want fffffffe", rd); end
    bus_read(32'h4000_0004, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tl_inc: got %h want ffffffff", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    bus_read(32'h4000_0004, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL tl_reload: got %h want fffffffe", rd); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_write(32'h4000_0008, 32'h0000_0003, 2'b10);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_write(32'h4000_0008, 32'h0000_0000, 2'b10);
`else
    bus_write(32'h4000_0004, 32'h0000_0055, 2'b10);
    bus_read(32'h4000_0004, 2'b10, 1'b0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL no_timer_tl: got %h want 0", rd); end
    bus_write(32'h4000_0008, 32'h0000_0003, 2'b10);
    repeat (4) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL no_timer_irq: got %b want 0", irq); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.addr = '0; bus.WriteData = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.MemSize = 2'b10; bus.MemSigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset;
    test_ram_lanes;
    test_misaligned;
    test_periph;
    test_reset_retain;
    test_scan;
    test_timer;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Parametrised successor to the pipeline CPU's data memory: word-organised RAM plus a memory-mapped peripheral window (LEDs, direct/auto-scanned 7-segment display, optional timer). Sits in the MEM stage. It serves byte, halfword and word loads/stores with combinational read data and clocked writes. Writes take effect only while MemWrite is high.

## Interface
- MEM_DEPTH, 512, RAM size in 32-bit words; byte address range 0 .. 4*MEM_DEPTH-1 (must be ≤ 0x40000000)
- LED_WIDTH, 8, LED register width (1..16)
- DIGITS, 4, 7-segment digit count (1..8)
- SCAN_DIV, 100000, clock cycles each digit is held in auto mode (≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  byte address
- WriteData  in  32  store data, right-aligned
- MemRead  in  1  read enable; ReadData = 0 when low
- MemWrite  in  1  write enable
- MemSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- MemSigned  in  1  sign-extend byte/halfword loads
- ReadData  out  32  combinational load data
- misaligned  out  1  combinational; halfword with addr[0]=1 or word with addr[1:0]≠0, qualified by MemRead|MemWrite
- leds  out  LED_WIDTH  LED register
- AN  out  DIGITS  digit anodes
- BCD  out  8  segment lines {dp,g,f,e,d,c,b,a}
- irq  out  1  timer interrupt (0 when timer compiled out)

## Operation
- Address map (byte):
  - RAM 0..4*MEM_DEPTH-1
  - 0x40000000 TH
  - 0x40000004 TL
  - 0x40000008 TCON
  - 0x4000000C LEDS
  - 0x40000010 DIRECT {AN[DIGITS-1:0] at bits 8+, BCD at 7:0}
  - 0x40000014 DISP (4*DIGITS-bit hex value)
  - 0x40000018 CTRL (bit0 = auto)
- Unmapped read → 0; unmapped write ignored.
- Misaligned access: write suppressed, ReadData = 0.
- RAM sub-word stores: only the addressed byte or halfword lanes change (little-endian, lane = addr[1:0]). Loads extract the same lane, zero- or sign-extended per MemSigned.
- Peripheral registers: word access only; sub-word peripheral writes are ignored, sub-word reads return 0. Reads return zero-extended register values.
- Display, CTRL.auto=0: AN/BCD come directly from DIRECT.
- Display, CTRL.auto=1: scanner drives outputs.
  - AN = ~(1<<idx), active-low one-hot.
  - BCD = active-low hex glyph of DISP nibble idx; dp off (1).
- Scanner: divider counts 0..SCAN_DIV-1. On the terminal count, idx advances by 1 and wraps at DIGITS-1 → 0. Scanner runs even when auto=0.
- Reset values:
  - leds, DIRECT, DISP, CTRL, TH, TL, TCON = 0; divider = 0; idx = 0.
  - RAM contents are NOT cleared by reset (retained).
  - Outputs after reset: leds=0, AN=0, BCD=0, irq=0.

## Timing
- Reads are combinational in the same cycle. Writes are visible on ReadData the cycle after the write edge.
- Reset has priority over a simultaneous write: the peripheral write is lost; a RAM write in the reset cycle is also suppressed.
- Mode switch: the AN/BCD source changes the cycle after the CTRL write. Scanner idx is unaffected by the switch.
- Timer (when compiled in):
  - Increment: while TCON[0]=1, TL increments each cycle.
  - Overflow: when TL=0xFFFFFFFF it loads TH instead of incrementing, and if TCON[1]=1, TCON[2] is set.
  - irq = TCON[2]. TCON[2] stays set until software writes TCON.
  - A CPU write to TL in the same cycle as an increment or overflow wins. A TCON write with bit2=0 in the overflow cycle clears the flag (write wins).

## Configuration
- DATA_MEM_TIMER_EN defined: the TH/TL/TCON registers and timer logic are present, with behaviour as above.
- DATA_MEM_TIMER_EN undefined: addresses 0x40000000–0x40000008 are unmapped (read 0, writes ignored) and irq is tied to 0.

## Structure
- Package data_mem_pkg holds:
  - address constants for every peripheral register
  - MemSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - the 16-entry hex-to-segment constant table
- Sub-module seg7_scan: divider, idx counter, nibble select and glyph decode. Parameters DIGITS and SCAN_DIV; inputs DISP; outputs scanned AN/BCD.
- The top level holds the RAM, lane logic, register file, output mux and timer.

## Test plan
- Word store 0x12345678 @0x10, then byte store 0xAB @0x11 → word load @0x10 = 0x1234AB78; signed byte load @0x11 = 0xFFFFFFAB; unsigned = 0x000000AB.
- Word store @0x12 → misaligned=1, RAM unchanged, ReadData=0. MemWrite=0 with addr 0x10 → RAM unchanged.
- Store 0xA5 @0x4000000C → leds=0xA5 next cycle. Store 0x0E3F @0x40000010 (auto=0) → AN=0xE, BCD=0x3F. Reset → leds=0, AN=0, BCD=0, and RAM @0x10 still 0x1234AB78.
- Run with SCAN_DIV=4; DISP=0x1234, CTRL=1 → AN steps 1110,1101,1011,0111 every 4 cycles with glyphs for 4,3,2,1 (active-low: 0x99,0xB0,0xA4,0xF9), then wraps.
- With timer: TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3 → TL=0xFFFFFFFF, then reload 0xFFFFFFFE with irq=1; write TCON=3 → irq=0. Without the macro, read @0x40000004 = 0 and irq stays 0.
- Unmapped read @0x40000020 → 0; peripheral byte store @0x4000000C → leds unchanged.
